// File: rtl/video_capture_if.sv
// video_capture_if: video timing/pixel bus into the capture block and capture results out of it
// master: the video source; it drives hsync, vsync, de and r/g/b and reads the capture results
// slave : video_capture; it reads the video bus and drives px_*, frame_*, locked and dbg_hsync
interface video_capture_if #(
  parameter int CORDW = 11
);
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic             px_valid;
  logic [CORDW-1:0] px_x;
  logic [CORDW-1:0] px_y;
  logic [23:0]      px_rgb;
  logic             frame_done;
  logic [CORDW-1:0] frame_w;
  logic [CORDW-1:0] frame_h;
  logic [31:0]      frame_sig;
  logic             frame_err;
  logic [15:0]      frame_cnt;
  logic             locked;
  logic             dbg_hsync;
  modport master (
    output hsync, vsync, de, r, g, b,
    input  px_valid, px_x, px_y, px_rgb, frame_done, frame_w, frame_h,
           frame_sig, frame_err, frame_cnt, locked, dbg_hsync
  );
  modport slave (
    input  hsync, vsync, de, r, g, b,
    output px_valid, px_x, px_y, px_rgb, frame_done, frame_w, frame_h,
           frame_sig, frame_err, frame_cnt, locked, dbg_hsync
  );
endinterface

// File: rtl/video_capture.sv
// video_capture: rebuilds pixel coordinates from de/vsync and measures each frame's geometry and signature
// clk_pix   : pixel clock
// rst_pix_n : synchronous active-low reset
// vif       : video bus in (hsync, vsync, de, r/g/b); pixel strobe and per-frame results out
module video_capture #(
  parameter int   CORDW    = 11,
  parameter logic SYNC_ACT = 1'b0
) (
  input logic            clk_pix,
  input logic            rst_pix_n,
  video_capture_if.slave vif
);
  localparam logic [0:0]       SEEK = 1'b0;
  localparam logic [0:0]       LOCK = 1'b1;
  localparam logic [CORDW-1:0] CMAX = {CORDW{1'b1}};
  logic             r_hs, r_vs, r_vs_d, r_de, r_de_d;
  logic [23:0]      r_rgb;
  logic [0:0]       r_state;
  logic [CORDW-1:0] r_x, r_y, r_ref_w;
  logic             r_ref_ok, r_err;
  logic [31:0]      r_sig;
  logic             r_px_valid, r_done, r_frame_err;
  logic [CORDW-1:0] r_px_x, r_px_y, r_frame_w, r_frame_h;
  logic [23:0]      r_px_rgb;
  logic [31:0]      r_frame_sig;
  logic [15:0]      r_frame_cnt;
  logic             w_lock, w_vs_edge, w_de_fall, w_px;
  logic [31:0]      w_sig_nxt;
  logic [CORDW-1:0] w_x_inc, w_y_inc;
  assign w_lock    = r_state == LOCK;
  assign w_vs_edge = (r_vs == SYNC_ACT) && (r_vs_d != SYNC_ACT);
  assign w_de_fall = r_de_d && !r_de;
  assign w_px      = w_lock && r_de;
  // the signature folds in a pixel accepted in the same cycle as the closing vsync edge
  assign w_sig_nxt = w_px ? {r_sig[30:0], r_sig[31]} ^ {8'h00, r_rgb} : r_sig;
  assign w_x_inc   = (r_x == CMAX) ? r_x : r_x + 1'b1;
  assign w_y_inc   = (r_y == CMAX) ? r_y : r_y + 1'b1;
  // sync regs reset to the inactive level so leaving reset cannot fake a vsync edge
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_hs   <= 1'b0;
      r_vs   <= ~SYNC_ACT;
      r_vs_d <= ~SYNC_ACT;
      r_de   <= 1'b0;
      r_de_d <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs   <= vif.hsync;
      r_vs   <= vif.vsync;
      r_vs_d <= r_vs;
      r_de   <= vif.de;
      r_de_d <= r_de;
      r_rgb  <= {vif.r, vif.g, vif.b};
    end
  end
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_state     <= SEEK;
      r_x         <= '0;
      r_y         <= '0;
      r_ref_w     <= '0;
      r_ref_ok    <= 1'b0;
      r_err       <= 1'b0;
      r_sig       <= '0;
      r_px_valid  <= 1'b0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_px_rgb    <= '0;
      r_done      <= 1'b0;
      r_frame_w   <= '0;
      r_frame_h   <= '0;
      r_frame_sig <= '0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_px_valid <= w_px;
      r_done     <= w_lock && w_vs_edge;
      if (w_px) begin
        r_px_x   <= r_x;
        r_px_y   <= r_y;
        r_px_rgb <= r_rgb;
      end
      if (w_vs_edge) r_state <= LOCK;
      if (w_lock && w_vs_edge) begin
        r_frame_w   <= r_ref_w;
        r_frame_h   <= r_y;
        r_frame_sig <= w_sig_nxt;
        r_frame_err <= r_err;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_x         <= '0;
        r_y         <= '0;
        r_ref_w     <= '0;
        r_ref_ok    <= 1'b0;
        r_err       <= 1'b0;
        r_sig       <= '0;
      end else if (w_lock) begin
        r_sig <= w_sig_nxt;
        if (r_de) r_x <= w_x_inc;
        // the first completed line of a frame sets the reference width, later lines are checked against it
        if (w_de_fall) begin
          r_x      <= '0;
          r_y      <= w_y_inc;
          r_ref_ok <= 1'b1;
          if (!r_ref_ok) r_ref_w <= r_x;
          else if (r_x != r_ref_w) r_err <= 1'b1;
        end
      end
    end
  end
  assign vif.px_valid   = r_px_valid;
  assign vif.px_x       = r_px_x;
  assign vif.px_y       = r_px_y;
  assign vif.px_rgb     = r_px_rgb;
  assign vif.frame_done = r_done;
  assign vif.frame_w    = r_frame_w;
  assign vif.frame_h    = r_frame_h;
  assign vif.frame_sig  = r_frame_sig;
  assign vif.frame_err  = r_frame_err;
  assign vif.frame_cnt  = r_frame_cnt;
  assign vif.locked     = w_lock;
  assign vif.dbg_hsync  = r_hs;
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed-vector bench for video_capture at CORDW=11 and CORDW=3
module tb_video_capture;
  logic        clk_pix = 1'b0;
  logic        rst_pix_n = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          base;
  int          d0;
  logic [10:0] mx[$];
  logic [10:0] my[$];
  logic [23:0] mc[$];
  logic [2:0]  m3x[$];
  video_capture_if #(.CORDW(11)) vif();
  video_capture_if #(.CORDW(3))  vif3();
  video_capture #(.CORDW(11), .SYNC_ACT(1'b0)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .vif(vif)
  );
  video_capture #(.CORDW(3), .SYNC_ACT(1'b0)) dut3 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .vif(vif3)
  );
  always #5 clk_pix = ~clk_pix;
  always @(negedge clk_pix) begin
    if (vif.px_valid) begin
      mx.push_back(vif.px_x);
      my.push_back(vif.px_y);
      mc.push_back(vif.px_rgb);
    end
    if (vif.frame_done) n_done++;
    if (vif3.px_valid) m3x.push_back(vif3.px_x);
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask
  task automatic line(input int w, input logic [23:0] c);
    for (int i = 0; i < w; i++) begin
      vif.de = 1'b1;
      {vif.r, vif.g, vif.b} = c;
      tick();
    end
    vif.de = 1'b0;
    {vif.r, vif.g, vif.b} = 24'h0;
    tick();
    tick();
  endtask
  task automatic frame(input int w0, input int w1, input int w2, input logic [23:0] c);
    line(w0, c);
    line(w1, c);
    line(w2, c);
  endtask
  task automatic vs_pulse();
    vif.vsync = 1'b0;
    tick();
    vif.vsync = 1'b1;
    tick();
    tick();
  endtask
  task automatic vs3_pulse();
    vif3.vsync = 1'b0;
    tick();
    vif3.vsync = 1'b1;
    tick();
    tick();
  endtask
  initial begin
    vif.hsync = 1'b1; vif.vsync = 1'b1; vif.de = 1'b0; {vif.r, vif.g, vif.b} = 24'h0;
    vif3.hsync = 1'b1; vif3.vsync = 1'b1; vif3.de = 1'b0; {vif3.r, vif3.g, vif3.b} = 24'h0;
    repeat (3) tick();
    rst_pix_n = 1'b1;
    tick();
    chk("rst_px_valid", vif.px_valid, 0);
    chk("rst_locked", vif.locked, 0);
    chk("rst_frame_cnt", vif.frame_cnt, 0);
    chk("rst_frame_done", vif.frame_done, 0);
    chk("rst_frame_w", vif.frame_w, 0);
    chk("rst_frame_sig", vif.frame_sig, 0);
    chk("rst_frame_err", vif.frame_err, 0);
    frame(4, 4, 4, 24'h000001);
    chk("seek_no_px", mx.size(), 0);
    chk("seek_locked", vif.locked, 0);
    vs_pulse();
    chk("lock_locked", vif.locked, 1);
    chk("lock_no_done", n_done, 0);
    base = mx.size();
    frame(4, 4, 4, 24'h000001);
    vs_pulse();
    chk("f1_px_count", mx.size() - base, 12);
    for (int i = 0; i < 12 && base + i < mx.size(); i++) begin
      chk("f1_px_x", mx[base+i], i % 4);
      chk("f1_px_y", my[base+i], i / 4);
    end
    if (mc.size() > base) chk("f1_px_rgb", mc[base], 24'h000001);
    chk("f1_done", n_done, 1);
    chk("f1_w", vif.frame_w, 4);
    chk("f1_h", vif.frame_h, 3);
    chk("f1_cnt", vif.frame_cnt, 1);
    chk("f1_err", vif.frame_err, 0);
    chk("f1_sig", vif.frame_sig, 32'h00000FFF);
    frame(4, 4, 5, 24'h000000);
    vs_pulse();
    chk("f2_err", vif.frame_err, 1);
    chk("f2_w", vif.frame_w, 4);
    chk("f2_h", vif.frame_h, 3);
    chk("f2_sig", vif.frame_sig, 0);
    chk("f2_cnt", vif.frame_cnt, 2);
    frame(4, 4, 4, 24'h000001);
    vs_pulse();
    chk("f3_err", vif.frame_err, 0);
    chk("f3_sig", vif.frame_sig, 32'h00000FFF);
    chk("f3_cnt", vif.frame_cnt, 3);
    vs_pulse();
    chk("empty_done", n_done, 4);
    chk("empty_w", vif.frame_w, 0);
    chk("empty_h", vif.frame_h, 0);
    chk("empty_sig", vif.frame_sig, 0);
    chk("empty_err", vif.frame_err, 0);
    chk("empty_cnt", vif.frame_cnt, 4);
    line(4, 24'h000001);
    vif.de = 1'b1;
    {vif.r, vif.g, vif.b} = 24'h000001;
    tick();
    tick();
    rst_pix_n = 1'b0;
    tick();
    rst_pix_n = 1'b1;
    chk("mid_rst_locked", vif.locked, 0);
    chk("mid_rst_px_valid", vif.px_valid, 0);
    chk("mid_rst_px_x", vif.px_x, 0);
    chk("mid_rst_cnt", vif.frame_cnt, 0);
    chk("mid_rst_w", vif.frame_w, 0);
    chk("mid_rst_h", vif.frame_h, 0);
    chk("mid_rst_sig", vif.frame_sig, 0);
    tick();
    base = mx.size();
    d0 = n_done;
    tick();
    vif.de = 1'b0;
    tick();
    tick();
    frame(4, 4, 4, 24'h000001);
    chk("post_rst_no_px", mx.size() - base, 0);
    vs_pulse();
    chk("post_rst_no_done", n_done - d0, 0);
    frame(4, 4, 4, 24'h000001);
    vs_pulse();
    chk("post_rst_done", n_done - d0, 1);
    chk("post_rst_cnt", vif.frame_cnt, 1);
    chk("post_rst_w", vif.frame_w, 4);
    chk("post_rst_h", vif.frame_h, 3);
    chk("post_rst_sig", vif.frame_sig, 32'h00000FFF);
    vs3_pulse();
    for (int i = 0; i < 10; i++) begin
      vif3.de = 1'b1;
      {vif3.r, vif3.g, vif3.b} = 24'h000002;
      tick();
    end
    vif3.de = 1'b0;
    tick();
    tick();
    vs3_pulse();
    chk("sat_px_count", m3x.size(), 10);
    if (m3x.size() == 10) begin
      chk("sat_px_x6", m3x[6], 6);
      chk("sat_px_x7", m3x[7], 7);
      chk("sat_px_x9", m3x[9], 7);
    end
    chk("sat_w", vif3.frame_w, 7);
    chk("sat_h", vif3.frame_h, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
